// File: rtl/fn_mux_pkg.sv
// Shared types and constants for the mux-tree truth-table evaluator.
package fn_mux_pkg;

    localparam logic [15:0] FN_DEFAULT = 16'hF81A;
    localparam int          LEG_W      = 4;

    typedef logic [1:0] sel_t;

endpackage : fn_mux_pkg

// File: rtl/function_using_mux_mux4.sv
// Generic 4x1 multiplexer; an unknown select propagates X to the output.
module mux4
    import fn_mux_pkg::*;
(
    input  logic [LEG_W-1:0] d,
    input  sel_t             s,
    output logic             y
);

    assign y = d[s];

endmodule : mux4

// File: rtl/function_using_mux.sv
// Evaluates F(A,B,C,D) from the FUNC truth table via a two-level mux4 tree, with a registered copy.
// Optional macro FN_EDGE_DET_EN adds a registered 0->1 pulse output y_rise.
module function_using_mux
    import fn_mux_pkg::*;
#(
    parameter logic [15:0] FUNC = FN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
`ifdef FN_EDGE_DET_EN
    output logic y_rise,
`endif
    output logic Y_comb,
    output logic Y
);

    logic [LEG_W-1:0] leg;
    logic             y_comb;
    logic             y_d;
    logic             y_q;

    // Each leg picks one bit of its FUNC nibble with {C,D}
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_leg
            mux4 u_leg (
                .d (FUNC[LEG_W*gi +: LEG_W]),
                .s ({C, D}),
                .y (leg[gi])
            );
        end
    endgenerate

    mux4 u_out (
        .d (leg),
        .s ({A, B}),
        .y (y_comb)
    );

    always_comb begin
        y_d = y_q;
        if (en) begin
            y_d = y_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

`ifdef FN_EDGE_DET_EN
    logic y_rise_d;
    logic y_rise_q;

    // Pulse only on enabled cycles where the stored value goes 0 -> 1
    always_comb begin
        y_rise_d = 1'b0;
        if (en) begin
            y_rise_d = ~y_q & y_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_rise_q <= 1'b0;
        end else begin
            y_rise_q <= y_rise_d;
        end
    end

    assign y_rise = y_rise_q;
`endif

    assign Y_comb = y_comb;
    assign Y      = y_q;

endmodule : function_using_mux

// File: tb/tb_function_using_mux.sv
// Directed-vector bench for function_using_mux (default FUNC and a 16'h8001 override).
module tb_function_using_mux;

    logic clk;
    logic rst_n;
    logic en;
    logic A, B, C, D;
    logic y_comb, y;
    logic y2_comb, y2;
`ifdef FN_EDGE_DET_EN
    logic y_rise, y2_rise;
`endif

    int tests;
    int fails;

    // Hand-derived default sequence for minterms 0..15
    logic exp_f [16] = '{0,1,0,1,1,0,0,0,0,0,0,1,1,1,1,1};

    function_using_mux dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
`ifdef FN_EDGE_DET_EN
        .y_rise (y_rise),
`endif
        .Y_comb (y_comb),
        .Y      (y)
    );

    function_using_mux #(.FUNC(16'h8001)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
`ifdef FN_EDGE_DET_EN
        .y_rise (y2_rise),
`endif
        .Y_comb (y2_comb),
        .Y      (y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] v);
        {A, B, C, D} = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        set_in(4'b1111);
        #1;
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL reset_y: got %b expected 0", y);
        end
        tests++;
        if (y_comb !== 1'b1) begin
            fails++;
            $display("FAIL reset_ycomb: got %b expected 1", y_comb);
        end
`ifdef FN_EDGE_DET_EN
        tests++;
        if (y_rise !== 1'b0) begin
            fails++;
            $display("FAIL reset_rise: got %b expected 0", y_rise);
        end
`endif
        @(posedge clk);
        #1;
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_edge: got %b expected 0", y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(4'b0000);
        @(negedge clk);
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got %b expected 0", y);
        end
        $display("[TB] reset: y=%b y_comb=%b", y, y_comb);
    endtask

    task automatic test_sweep();
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (y !== exp_f[i-1]) begin
                    fails++;
                    $display("FAIL sweep_y[%0d]: got %b expected %b", i - 1, y, exp_f[i-1]);
                end
            end
            set_in(4'(i));
            #1;
            tests++;
            if (y_comb !== exp_f[i]) begin
                fails++;
                $display("FAIL sweep_ycomb[%0d]: got %b expected %b", i, y_comb, exp_f[i]);
            end
            $display("[TB] sweep m%0d: y_comb=%b", i, y_comb);
        end
        @(negedge clk);
        tests++;
        if (y !== exp_f[15]) begin
            fails++;
            $display("FAIL sweep_y[15]: got %b expected %b", y, exp_f[15]);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b1;
        set_in(4'b1111);
        @(negedge clk);
        tests++;
        if (y !== 1'b1) begin
            fails++;
            $display("FAIL hold_load: got %b expected 1", y);
        end
        en = 1'b0;
        set_in(4'b0000);
        repeat (3) @(negedge clk);
        tests++;
        if (y !== 1'b1) begin
            fails++;
            $display("FAIL hold_y: got %b expected 1", y);
        end
        tests++;
        if (y_comb !== 1'b0) begin
            fails++;
            $display("FAIL hold_ycomb: got %b expected 0", y_comb);
        end
`ifdef FN_EDGE_DET_EN
        tests++;
        if (y_rise !== 1'b0) begin
            fails++;
            $display("FAIL hold_rise: got %b expected 0", y_rise);
        end
`endif
        $display("[TB] hold: y=%b y_comb=%b", y, y_comb);
    endtask

    task automatic test_async_reset();
        // Y is 1 from the hold test; pulse reset mid-cycle
        @(negedge clk);
        en = 1'b1;
        set_in(4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %b expected 0", y);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (y !== 1'b1) begin
            fails++;
            $display("FAIL async_reload: got %b expected 1", y);
        end
        $display("[TB] async reset: y=%b", y);
    endtask

    task automatic test_override();
        logic e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(4'(i));
            #1;
            e = (i == 0 || i == 15);
            tests++;
            if (y2_comb !== e) begin
                fails++;
                $display("FAIL override_ycomb[%0d]: got %b expected %b", i, y2_comb, e);
            end
            $display("[TB] override m%0d: y_comb=%b", i, y2_comb);
        end
    endtask

    task automatic test_edge_det();
`ifdef FN_EDGE_DET_EN
        @(negedge clk);
        en = 1'b1;
        set_in(4'b0000);
        @(negedge clk);
        tests++;
        if (y_rise !== 1'b0 || y !== 1'b0) begin
            fails++;
            $display("FAIL edge_idle: got rise=%b y=%b expected 0 0", y_rise, y);
        end
        set_in(4'b0001);
        @(negedge clk);
        tests++;
        if (y_rise !== 1'b1 || y !== 1'b1) begin
            fails++;
            $display("FAIL edge_pulse: got rise=%b y=%b expected 1 1", y_rise, y);
        end
        @(negedge clk);
        tests++;
        if (y_rise !== 1'b0) begin
            fails++;
            $display("FAIL edge_one_cycle: got %b expected 0", y_rise);
        end
        set_in(4'b0011);
        @(negedge clk);
        tests++;
        if (y_rise !== 1'b0 || y !== 1'b1) begin
            fails++;
            $display("FAIL edge_stay_high: got rise=%b y=%b expected 0 1", y_rise, y);
        end
        $display("[TB] edge detect: y_rise=%b y=%b", y_rise, y);
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        set_in(4'b0000);
        test_reset();
        test_sweep();
        test_hold();
        test_async_reset();
        test_override();
        test_edge_det();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_function_using_mux
